// File: rtl/tick_uart_reporter.sv
// tick_uart_reporter: latches counter on each tick edge and sends it as two hex ASCII digits plus CR LF over 8N1 UART.
module tick_uart_reporter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic [7:0] counter,
  output logic       tx,
  output logic       busy,
  output logic       dropped
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state;
  logic          r_tick_q;
  logic [7:0]    r_val;
  logic [1:0]    r_byte_idx;
  logic [2:0]    r_bit_idx;
  logic [TW-1:0] r_timer;
  logic          r_tx;
  logic          r_busy;
  logic          r_dropped;
  logic          w_edge;
  logic          w_last;
  logic [3:0]    w_nib;
  logic [7:0]    w_hex;
  logic [7:0]    w_byte;
  logic [2:0]    w_next_bit;
  assign w_edge     = tick & ~r_tick_q;
  assign w_last     = r_timer == TW'(CLKS_PER_BIT - 1);
  assign w_nib      = r_byte_idx[0] ? r_val[3:0] : r_val[7:4];
  assign w_hex      = (w_nib < 4'd10) ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
  assign w_byte     = r_byte_idx[1] ? (r_byte_idx[0] ? 8'h0A : 8'h0D) : w_hex;
  assign w_next_bit = r_bit_idx + 3'd1;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign dropped    = r_dropped;
  // tx is loaded with the next bit's level on the edge that ends the current bit
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_tick_q   <= 1'b0;
      r_val      <= '0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
      r_timer    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_dropped  <= 1'b0;
    end else begin
      r_tick_q  <= tick;
      r_dropped <= w_edge && (r_state != IDLE);
      if (r_state == IDLE) begin
        if (w_edge) begin
          r_val      <= counter;
          r_byte_idx <= '0;
          r_timer    <= '0;
          r_state    <= START;
          r_tx       <= 1'b0;
          r_busy     <= 1'b1;
        end
      end else if (!w_last) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= '0;
        case (r_state)
          START: begin
            r_state   <= DATA;
            r_bit_idx <= '0;
            r_tx      <= w_byte[0];
          end
          DATA: begin
            if (r_bit_idx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= w_next_bit;
              r_tx      <= w_byte[w_next_bit];
            end
          end
          STOP: begin
            if (r_byte_idx != 2'd3) begin
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= START;
              r_tx       <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tick_uart_reporter.sv
// tb_tick_uart_reporter: table-driven frame checks plus reset and mid-frame reset sequences.
module tb_tick_uart_reporter;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] counter = 8'h00;
  logic       tx, busy, dropped;
  int         n_pass = 0;
  int         n_total = 0;
  int         cyc, hold_len, pulse_at, nbusy, ndrop;
  typedef struct {
    logic [7:0]  val;
    int          hold;
    int          pulse;
    logic [31:0] bytes;
    int          drops;
  } vec_t;
  vec_t vecs[6];
  vec_t vec_a5;
  tick_uart_reporter #(.CLKS_PER_BIT(4)) dut (
    .CLK(CLK), .RST(RST), .tick(tick), .counter(counter),
    .tx(tx), .busy(busy), .dropped(dropped)
  );
  always #5 CLK = ~CLK;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask
  task automatic step();
    @(negedge CLK);
    if (busy) nbusy++;
    if (dropped) ndrop++;
    cyc++;
    tick = (cyc < hold_len) || (cyc == pulse_at);
    if (cyc == pulse_at) counter = 8'h34;
  endtask
  task automatic run_vec(input vec_t v);
    logic [9:0] fr;
    logic [7:0] b;
    cyc = 0; hold_len = v.hold; pulse_at = v.pulse; nbusy = 0; ndrop = 0;
    counter = v.val;
    tick = 1'b1;
    step();
    check($sformatf("latency %h", v.val), {30'd0, tx, busy}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      for (int t = 0; t < 20 && tx; t++) step();
      step(); step();
      fr[0] = tx;
      for (int i = 1; i < 10; i++) begin
        repeat (4) step();
        fr[i] = tx;
      end
      b = v.bytes[31 - 8*k -: 8];
      check($sformatf("frame %h byte %0d", v.val, k), {22'd0, fr}, {22'd0, 1'b1, b, 1'b0});
    end
    while (cyc < 400) step();
    check($sformatf("busy cycles %h", v.val), nbusy, 160);
    check($sformatf("dropped pulses %h", v.val), ndrop, v.drops);
  endtask
  initial begin
    logic ok;
    vecs[0] = '{8'h3A, 1,   0,  32'h33410D0A, 0};
    vecs[1] = '{8'h09, 1,   0,  32'h30390D0A, 0};
    vecs[2] = '{8'hFF, 1,   0,  32'h46460D0A, 0};
    vecs[3] = '{8'h00, 1,   0,  32'h30300D0A, 0};
    vecs[4] = '{8'h12, 1,   50, 32'h31320D0A, 1};
    vecs[5] = '{8'h7C, 300, 0,  32'h37430D0A, 0};
    vec_a5  = '{8'hA5, 1,   0,  32'h41350D0A, 0};
    for (int i = 0; i < 5; i++) begin
      tick = 1'($urandom_range(0, 1));
      counter = 8'($urandom);
      @(negedge CLK);
      check("reset outputs", {29'd0, tx, busy, dropped}, 32'd4);
    end
    tick = 1'b0;
    RST = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if ({tx, busy, dropped} !== 3'b100) ok = 1'b0;
    end
    check("idle after reset", {31'd0, ok}, 32'd1);
    foreach (vecs[i]) run_vec(vecs[i]);
    cyc = 0; hold_len = 1; pulse_at = 0; nbusy = 0; ndrop = 0;
    counter = 8'h3A;
    tick = 1'b1;
    repeat (60) step();
    #2 RST = 1'b1;
    #1;
    check("async reset busy", {31'd0, busy}, 32'd0);
    check("async reset tx", {31'd0, tx}, 32'd1);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    run_vec(vec_a5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/tick_uart_reporter.md
# tick_uart_reporter

Downstream consumer of the per-second counter stage. On each rising edge of `tick` it latches the 8-bit `counter` value and transmits it over a UART TX line as two uppercase ASCII hex digits followed by CR LF (8N1, LSB first). Its output is the board's serial console, so the host can read the running counter without any display hardware.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200 baud); legal range ≥ 2.
- `CLK`  in  1: system clock; all logic on posedge.
- `RST`  in  1: reset. Asynchronous and active-high.
- `tick`  in  1: frame request; a rising edge requests one frame.
- `counter`  in  8: value to report; sampled only on an accepted tick edge.
- `tx`  out  1: UART serial output; idles high.
- `busy`  out  1: high while a frame is in flight.
- `dropped`  out  1: one-cycle pulse when a tick edge arrives while busy.

## Operation
- Edge detect: `tick_q` registers `tick`. An edge is `tick & ~tick_q`. A level held high for many cycles yields one edge. If `tick` is high on the first cycle after reset, that counts as an edge (`tick_q` resets to 0).
- Accept: when the state is IDLE and an edge is seen, latch `counter` into `val`, set byte index to 0 and enter START. Any edge seen outside IDLE is ignored and raises `dropped` for exactly that cycle. Later changes on `counter` do not affect a frame in flight.
- Frame bytes, in order:
  - byte 0: hex(`val[7:4]`)
  - byte 1: hex(`val[3:0]`)
  - byte 2: 0x0D
  - byte 3: 0x0A
- Hex rule: nibble n in 0–9 maps to 0x30+n; n in 10–15 maps to 0x41+(n−10). Uppercase only.
- States:
  - IDLE: `tx`=1.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: bits 0..7 sent LSB first, one bit period each, then go to STOP.
  - STOP: `tx`=1 for one bit period. If the byte index is below 3, increment it and go to START. Otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT−1 and wraps. Its width is $clog2(CLKS_PER_BIT). The bit index is 3 bits.
- `busy` = (state ≠ IDLE).
- `tx`, `busy` and `dropped` are all registered outputs, with no combinational path from the inputs.

## Timing
- Reset values: `tx`=1, `busy`=0, `dropped`=0, state IDLE, `tick_q`=0, `val`=0, all timers and indices 0.
- Async reset: `tx` returns to 1 and `busy` to 0 immediately on `RST` assertion, including mid-frame. No partial frame resumes after reset.
- Latency: tick edge sampled at clock N gives `tx`=0 (start bit) and `busy`=1 from cycle N+1.
- Each bit lasts exactly CLKS_PER_BIT cycles. Each byte is 10 bit periods.
- Bytes are sent back-to-back: byte k's stop bit is followed directly by byte k+1's start bit, with no idle gap.
- The whole frame is 40·CLKS_PER_BIT cycles. `busy` falls in the cycle after the last stop-bit cycle.
- A tick edge in the final stop-bit cycle (state still STOP) is dropped. An edge in the first IDLE cycle is accepted.
- `dropped` is high for one cycle per rejected edge, in the cycle after the edge is sampled.

## Test plan
- Reset: hold `RST`=1 with random inputs. Required: `tx`=1, `busy`=0, `dropped`=0. Release reset with `tick`=0; all outputs remain unchanged for 1000 cycles.
- Basic frame: CLKS_PER_BIT=4, `counter`=0x3A, 1-cycle `tick`. Required: decoded bytes 0x33, 0x41, 0x0D, 0x0A; `busy` high for exactly 160 cycles; start bit begins the cycle after the edge.
- Hex boundaries: run with `counter`=0x09, then 0xFF, then 0x00. Required bytes: 0x30 0x39 / 0x46 0x46 / 0x30 0x30, each followed by 0x0D 0x0A.
- Overrun: with `counter`=0x12, tick, then change `counter` to 0x34 and pulse `tick` again at cycle 50. Required: frame reads "12\r\n"; `dropped` high for exactly 1 cycle; no second frame.
- Held tick: hold `tick` high for 300 cycles with CLKS_PER_BIT=4. Required: exactly one frame and `dropped` never asserted.
- Reset mid-frame: assert `RST` during byte 1. Required: `tx`=1 and `busy`=0 immediately. After release, a new tick with `counter`=0xA5 yields a clean "A5\r\n" frame.
